// File: rtl/demux2_tdm_pkg.sv
// Shared constants for the TDM demux and its serializer counterpart.
// Channel ids and default geometry live here so both sides agree.
package demux2_tdm_pkg;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    // Width needed to hold an occupancy of 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/demux_fifo.sv
// Per-channel synchronous FIFO for the TDM demux.
// Head word is registered; the head reads as zero while empty.
module demux_fifo
    import demux2_tdm_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [cnt_w(DEPTH)-1:0]    count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign count   = cnt;
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage write; contents need no reset since empty masks the head.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/demux2_tdm.sv
// Receive-side 1:2 demux: steers a time-multiplexed word stream
// into two per-channel FIFOs by Select or round-robin pointer.
module demux2_tdm
    import demux2_tdm_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic [WIDTH-1:0]              In_data,
    input  logic                          In_valid,
    output logic                          In_ready,
    input  logic                          Select,
    input  logic                          Auto,
    input  logic                          Sync,
    output logic [WIDTH-1:0]              Out0_data,
    output logic                          Out0_valid,
    input  logic                          Out0_ready,
    output logic [WIDTH-1:0]              Out1_data,
    output logic                          Out1_valid,
    input  logic                          Out1_ready,
    output logic [$clog2(DEPTH+1)-1:0]    Count0,
    output logic [$clog2(DEPTH+1)-1:0]    Count1
);

    logic rr;
    logic dest;
    logic accept;
    logic full0;
    logic full1;
    logic empty0;
    logic empty1;

    // Sync overrides the pointer so a frame always starts on channel 0.
    always_comb begin
        dest = Select;
        if (Auto) begin
            dest = Sync ? CH0 : rr;
        end
    end

    assign In_ready   = (dest == CH1) ? ~full1 : ~full0;
    assign accept     = In_valid & In_ready;
    assign Out0_valid = ~empty0;
    assign Out1_valid = ~empty1;

    // Round-robin pointer: Sync realigns, accepts in Auto mode advance.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            rr <= CH0;
        end else if (Sync) begin
            rr <= accept ? CH1 : CH0;
        end else if (accept && Auto) begin
            rr <= ~rr;
        end
    end

    demux_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo0 (
        .clk   (Clk),
        .rst_n (Reset_n),
        .push  (accept && (dest == CH0)),
        .pop   (Out0_ready),
        .din   (In_data),
        .dout  (Out0_data),
        .empty (empty0),
        .full  (full0),
        .count (Count0)
    );

    demux_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo1 (
        .clk   (Clk),
        .rst_n (Reset_n),
        .push  (accept && (dest == CH1)),
        .pop   (Out1_ready),
        .din   (In_data),
        .dout  (Out1_data),
        .empty (empty1),
        .full  (full1),
        .count (Count1)
    );

endmodule

// File: tb/tb_demux2_tdm.sv
// Directed bench for demux2_tdm: vector table plus hand sequences
// for the multi-cycle push/pop and reset corner cases.
module tb_demux2_tdm;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic [7:0] In_data;
    logic       In_valid;
    logic       In_ready;
    logic       Select;
    logic       Auto;
    logic       Sync;
    logic [7:0] Out0_data;
    logic       Out0_valid;
    logic       Out0_ready;
    logic [7:0] Out1_data;
    logic       Out1_valid;
    logic       Out1_ready;
    logic [2:0] Count0;
    logic [2:0] Count1;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    demux2_tdm #(
        .WIDTH (8),
        .DEPTH (4)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .In_data    (In_data),
        .In_valid   (In_valid),
        .In_ready   (In_ready),
        .Select     (Select),
        .Auto       (Auto),
        .Sync       (Sync),
        .Out0_data  (Out0_data),
        .Out0_valid (Out0_valid),
        .Out0_ready (Out0_ready),
        .Out1_data  (Out1_data),
        .Out1_valid (Out1_valid),
        .Out1_ready (Out1_ready),
        .Count0     (Count0),
        .Count1     (Count1)
    );

    typedef struct {
        logic       rst_n;
        logic [7:0] d;
        logic       v;
        logic       sel;
        logic       au;
        logic       sy;
        logic       r0;
        logic       r1;
        logic       e_rdy;
        logic       e_v0;
        logic [7:0] e_d0;
        logic       e_v1;
        logic [7:0] e_d1;
        logic [2:0] e_c0;
        logic [2:0] e_c1;
    } vec_t;

    vec_t tbl [27];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drv(input logic rst, input logic [7:0] d,
                       input logic v, input logic sel, input logic au,
                       input logic sy, input logic r0, input logic r1);
        @(negedge Clk);
        Reset_n    = rst;
        In_data    = d;
        In_valid   = v;
        Select     = sel;
        Auto       = au;
        Sync       = sy;
        Out0_ready = r0;
        Out1_ready = r1;
        #1;
    endtask

    task automatic chk_all(input string tag, input logic rdy,
                           input logic v0, input logic [7:0] d0,
                           input logic v1, input logic [7:0] d1,
                           input logic [2:0] c0, input logic [2:0] c1);
        chk({tag, " in_ready"}, 32'(In_ready), 32'(rdy));
        chk({tag, " out0_valid"}, 32'(Out0_valid), 32'(v0));
        chk({tag, " out0_data"}, 32'(Out0_data), 32'(d0));
        chk({tag, " out1_valid"}, 32'(Out1_valid), 32'(v1));
        chk({tag, " out1_data"}, 32'(Out1_data), 32'(d1));
        chk({tag, " count0"}, 32'(Count0), 32'(c0));
        chk({tag, " count1"}, 32'(Count1), 32'(c1));
    endtask

    initial begin
        // round-robin split with sync pulse
        tbl[0]  = '{1, 8'h11, 1, 0, 1, 1, 1, 1, 1, 0, 8'h00, 0, 8'h00, 0, 0};
        tbl[1]  = '{1, 8'h22, 1, 0, 1, 0, 1, 1, 1, 1, 8'h11, 0, 8'h00, 1, 0};
        tbl[2]  = '{1, 8'h33, 1, 0, 1, 0, 1, 1, 1, 0, 8'h00, 1, 8'h22, 0, 1};
        tbl[3]  = '{1, 8'h44, 1, 0, 1, 0, 1, 1, 1, 1, 8'h33, 0, 8'h00, 1, 0};
        tbl[4]  = '{1, 8'h00, 0, 0, 1, 0, 1, 1, 1, 0, 8'h00, 1, 8'h44, 0, 1};
        tbl[5]  = '{1, 8'h00, 0, 0, 1, 0, 1, 1, 1, 0, 8'h00, 0, 8'h00, 0, 0};
        // fill channel 1, stall, pop one, then accept
        tbl[6]  = '{1, 8'hA1, 1, 1, 0, 0, 1, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0};
        tbl[7]  = '{1, 8'hA2, 1, 1, 0, 0, 1, 0, 1, 0, 8'h00, 1, 8'hA1, 0, 1};
        tbl[8]  = '{1, 8'hA3, 1, 1, 0, 0, 1, 0, 1, 0, 8'h00, 1, 8'hA1, 0, 2};
        tbl[9]  = '{1, 8'hA4, 1, 1, 0, 0, 1, 0, 1, 0, 8'h00, 1, 8'hA1, 0, 3};
        tbl[10] = '{1, 8'hA5, 1, 1, 0, 0, 1, 0, 0, 0, 8'h00, 1, 8'hA1, 0, 4};
        tbl[11] = '{1, 8'hA5, 1, 1, 0, 0, 1, 1, 0, 0, 8'h00, 1, 8'hA1, 0, 4};
        tbl[12] = '{1, 8'hA5, 1, 1, 0, 0, 1, 0, 1, 0, 8'h00, 1, 8'hA2, 0, 3};
        tbl[13] = '{1, 8'h00, 0, 1, 0, 0, 1, 0, 0, 0, 8'h00, 1, 8'hA2, 0, 4};
        // ch1 full, switch to ch0 same cycle
        tbl[14] = '{1, 8'hB1, 1, 0, 0, 0, 1, 0, 1, 0, 8'h00, 1, 8'hA2, 0, 4};
        tbl[15] = '{1, 8'h00, 0, 0, 0, 0, 0, 0, 1, 1, 8'hB1, 1, 8'hA2, 1, 4};
        tbl[16] = '{1, 8'h00, 0, 0, 0, 0, 1, 1, 1, 1, 8'hB1, 1, 8'hA2, 1, 4};
        tbl[17] = '{1, 8'h00, 0, 0, 0, 0, 1, 1, 1, 0, 8'h00, 1, 8'hA3, 0, 3};
        tbl[18] = '{1, 8'h00, 0, 0, 0, 0, 1, 1, 1, 0, 8'h00, 1, 8'hA4, 0, 2};
        tbl[19] = '{1, 8'h00, 0, 0, 0, 0, 1, 1, 1, 0, 8'h00, 1, 8'hA5, 0, 1};
        tbl[20] = '{1, 8'h00, 0, 0, 0, 0, 1, 1, 1, 0, 8'h00, 0, 8'h00, 0, 0};
        // rr=1 then sync with accept of 0xA5
        tbl[21] = '{1, 8'hC1, 1, 0, 1, 0, 0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0};
        tbl[22] = '{1, 8'hA5, 1, 0, 1, 1, 0, 0, 1, 1, 8'hC1, 0, 8'h00, 1, 0};
        tbl[23] = '{1, 8'hC2, 1, 0, 1, 0, 0, 0, 1, 1, 8'hC1, 0, 8'h00, 2, 0};
        tbl[24] = '{1, 8'h00, 0, 0, 1, 0, 1, 1, 1, 1, 8'hC1, 1, 8'hC2, 2, 1};
        tbl[25] = '{1, 8'h00, 0, 0, 1, 0, 1, 1, 1, 1, 8'hA5, 0, 8'h00, 1, 0};
        tbl[26] = '{1, 8'h00, 0, 0, 1, 0, 1, 1, 1, 0, 8'h00, 0, 8'h00, 0, 0};

        // initial reset
        Reset_n = 1'b0; In_data = '0; In_valid = 1'b0; Select = 1'b0;
        Auto = 1'b0; Sync = 1'b0; Out0_ready = 1'b0; Out1_ready = 1'b0;
        drv(0, 8'h00, 0, 0, 0, 0, 0, 0);
        drv(0, 8'h00, 0, 0, 0, 0, 0, 0);
        chk_all("reset", 1, 0, 8'h00, 0, 8'h00, 0, 0);

        for (int i = 0; i < 27; i++) begin
            drv(tbl[i].rst_n, tbl[i].d, tbl[i].v, tbl[i].sel,
                tbl[i].au, tbl[i].sy, tbl[i].r0, tbl[i].r1);
            chk_all($sformatf("vec%0d", i), tbl[i].e_rdy,
                    tbl[i].e_v0, tbl[i].e_d0, tbl[i].e_v1, tbl[i].e_d1,
                    tbl[i].e_c0, tbl[i].e_c1);
        end

        // steady push/pop on channel 0 at occupancy 2
        drv(1, 8'hD0, 1, 0, 0, 0, 0, 0);
        drv(1, 8'hD1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            drv(1, 8'(8'hD2 + i), 1, 0, 0, 0, 1, 0);
            chk($sformatf("pp%0d count0", i), 32'(Count0), 32'd2);
            chk($sformatf("pp%0d data0", i), 32'(Out0_data),
                32'(8'hD0 + i));
            chk($sformatf("pp%0d in_ready", i), 32'(In_ready), 32'd1);
        end
        drv(1, 8'h00, 0, 0, 0, 0, 1, 0);
        chk("pp drain0", 32'(Out0_data), 32'hDA);
        drv(1, 8'h00, 0, 0, 0, 0, 1, 0);
        chk("pp drain1", 32'(Out0_data), 32'hDB);
        drv(1, 8'h00, 0, 0, 0, 0, 1, 0);
        chk("pp empty", 32'(Out0_valid), 32'd0);

        // load 3 words per channel leaving rr=1, then reset
        for (int i = 0; i < 5; i++) begin
            drv(1, 8'(8'hF0 + i), 1, 0, 1, 0, 0, 0);
        end
        drv(1, 8'hF5, 1, 1, 0, 0, 0, 0);
        drv(1, 8'h00, 0, 0, 0, 0, 0, 0);
        chk_all("preload", 1, 1, 8'hF0, 1, 8'hF1, 3, 3);
        drv(0, 8'hEE, 1, 0, 1, 0, 0, 0);
        drv(1, 8'h00, 0, 0, 1, 0, 0, 0);
        chk_all("midreset", 1, 0, 8'h00, 0, 8'h00, 0, 0);
        drv(1, 8'hE1, 1, 0, 1, 0, 0, 0);
        drv(1, 8'h00, 0, 0, 1, 0, 0, 0);
        chk_all("postreset", 1, 1, 8'hE1, 0, 8'h00, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
